icache_assoc: RTL and testbench

- Parametrised set-associative instruction cache for the pipelined MIPS core.
- Successor to the fixed direct-mapped icache instantiated beside the dcache in the caches wrapper.
- Generalised in sets, ways and words-per-block.
- Adds round-robin replacement, multi-word burst refill, a sequenced invalidate, and hit/miss performance counters.
- Sits between the datapath instruction port and the memory-controller instruction channel.

---
 rtl/icache_assoc.sv | 187 ++++++++++++++++++
 tb/tb_icache_assoc.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_assoc.sv
// Set-associative instruction cache: round-robin replacement, burst refill from the
// memory controller, one-set-per-cycle invalidate and free-running hit/miss counters.
module icache_assoc #(
    parameter int SETS  = 8,
    parameter int WAYS  = 2,
    parameter int WORDS = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        flush,
    output logic        flushed,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hitcnt,
    output logic [31:0] misscnt
);
    localparam int WO = $clog2(WORDS);
    localparam int IX = $clog2(SETS);
    localparam int TW = 30 - WO - IX;
    localparam int CW = (WO > 0) ? WO : 1;
    localparam int PW = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, FILL, INVAL} state_t;
    state_t state_q, state_d;

    logic [WAYS-1:0] valid_q [SETS];
    logic [TW-1:0]   tag_q   [SETS][WAYS];
    logic [31:0]     data_q  [SETS][WAYS][WORDS];
    logic [PW-1:0]   ptr_q   [SETS];

    logic [TW-1:0] ltag_q;
    logic [IX-1:0] lidx_q;
    logic [PW-1:0] victim_q;
    logic [CW-1:0] cnt_q;
    logic [IX-1:0] set_q;
    logic [31:0]   hitcnt_q;
    logic [31:0]   misscnt_q;
    logic          flushed_q;

    logic [TW-1:0] req_tag;
    logic [IX-1:0] req_idx;
    logic [CW-1:0] req_word;
    logic          unused_ok;

    assign req_tag   = imemaddr[31 -: TW];
    assign req_idx   = imemaddr[2+WO +: IX];
    assign unused_ok = ^imemaddr[1:0];

    generate
        if (WO > 0) begin : g_word
            assign req_word = imemaddr[2 +: WO];
        end else begin : g_noword
            assign req_word = '0;
        end
    endgenerate

    logic [WAYS-1:0] match;
    logic [WAYS-1:0] invalid;
    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_way
            assign match[gi]   = valid_q[req_idx][gi] && (tag_q[req_idx][gi] == req_tag);
            assign invalid[gi] = !valid_q[req_idx][gi];
        end
    endgenerate

    logic          any_match;
    logic          any_invalid;
    logic [PW-1:0] hit_way;
    logic [PW-1:0] free_way;
    logic [PW-1:0] victim;

    // Descending scan so the lowest-numbered way wins.
    always_comb begin
        hit_way  = '0;
        free_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (match[w])   hit_way  = PW'(w);
            if (invalid[w]) free_way = PW'(w);
        end
    end

    assign any_match   = |match;
    assign any_invalid = |invalid;
    assign victim      = any_invalid ? free_way : ptr_q[req_idx];

    logic miss_take;
    logic word_last;
    assign miss_take = (state_q == IDLE) && !flush && imemREN && !any_match;
    assign word_last = (cnt_q == CW'(WORDS - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            ltag_q    <= '0;
            lidx_q    <= '0;
            victim_q  <= '0;
            cnt_q     <= '0;
            set_q     <= '0;
            hitcnt_q  <= '0;
            misscnt_q <= '0;
            flushed_q <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
        end else begin
            state_q   <= state_d;
            flushed_q <= (state_q == INVAL) && (set_q == IX'(SETS - 1));
            case (state_q)
                IDLE: begin
                    if (ihit) hitcnt_q <= hitcnt_q + 32'd1;
                    if (flush) set_q <= '0;
                    if (miss_take) begin
                        ltag_q    <= req_tag;
                        lidx_q    <= req_idx;
                        victim_q  <= victim;
                        cnt_q     <= '0;
                        misscnt_q <= misscnt_q + 32'd1;
                        // Pointer only moves when a live block is evicted.
                        if (!any_invalid && WAYS > 1) ptr_q[req_idx] <= ptr_q[req_idx] + PW'(1);
                    end
                end
                FILL: begin
                    if (!iwait) begin
                        cnt_q <= cnt_q + CW'(1);
                        if (word_last) valid_q[lidx_q][victim_q] <= 1'b1;
                    end
                end
                INVAL: begin
                    valid_q[set_q] <= '0;
                    ptr_q[set_q]   <= '0;
                    set_q          <= set_q + IX'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && state_q == FILL && !iwait) begin
            data_q[lidx_q][victim_q][cnt_q] <= iload;
            if (word_last) tag_q[lidx_q][victim_q] <= ltag_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (flush)          state_d = INVAL;
                else if (miss_take) state_d = FILL;
            end
            FILL:    if (!iwait && word_last) state_d = IDLE;
            INVAL:   if (set_q == IX'(SETS - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ihit     = 1'b0;
        imemload = '0;
        iREN     = 1'b0;
        iaddr    = '0;
        case (state_q)
            IDLE: begin
                ihit = imemREN && !flush && any_match;
                if (ihit) imemload = data_q[req_idx][hit_way][req_word];
            end
            FILL: begin
                iREN  = 1'b1;
                iaddr = {ltag_q, lidx_q, {(WO + 2){1'b0}}} | (32'(cnt_q) << 2);
            end
            default: ;
        endcase
    end

    assign flushed = flushed_q;
    assign hitcnt  = hitcnt_q;
    assign misscnt = misscnt_q;
endmodule

// File: tb/tb_icache_assoc.sv
// Bench for icache_assoc: default (8x2x2) instance plus a 4x4x4 instance, checked
// against an array-based cache model with a scripted memory responder.
module tb_icache_assoc;
    logic        CLK = 1'b0;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        flush;

    logic        ihit_a, flushed_a, iren_a;
    logic        iwait_a = 1'b0;
    logic [31:0] load_a, iaddr_a, iload_a, hitcnt_a, misscnt_a;
    logic        ihit_b, flushed_b, iren_b;
    logic        iwait_b = 1'b0;
    logic [31:0] load_b, iaddr_b, iload_b, hitcnt_b, misscnt_b;

    icache_assoc #(.SETS(8), .WAYS(2), .WORDS(2)) dut_a (
        .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit_a), .imemload(load_a), .flush(flush), .flushed(flushed_a),
        .iREN(iren_a), .iaddr(iaddr_a), .iwait(iwait_a), .iload(iload_a),
        .hitcnt(hitcnt_a), .misscnt(misscnt_a));

    icache_assoc #(.SETS(4), .WAYS(4), .WORDS(4)) dut_b (
        .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit_b), .imemload(load_b), .flush(flush), .flushed(flushed_b),
        .iREN(iren_b), .iaddr(iaddr_b), .iwait(iwait_b), .iload(iload_b),
        .hitcnt(hitcnt_b), .misscnt(misscnt_b));

    always #5 CLK = ~CLK;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return 32'hAAAA0000 + (a >> 2) - 32'd15;
    endfunction

    assign iload_a = memf(iaddr_a);
    assign iload_b = memf(iaddr_b);

    // Memory responder: mem_wait busy cycles before every accepted word.
    int mem_wait = 0;
    int wcnt_a = 0;
    int wcnt_b = 0;
    always @(posedge CLK) begin
        #2;
        if (iren_a && wcnt_a < mem_wait) begin iwait_a = 1'b1; wcnt_a++; end
        else begin iwait_a = 1'b0; wcnt_a = 0; end
        if (iren_b && wcnt_b < mem_wait) begin iwait_b = 1'b1; wcnt_b++; end
        else begin iwait_b = 1'b0; wcnt_b = 0; end
    end

    bit sel_b = 1'b0;
    logic        cur_ihit, cur_iren, cur_iwait, cur_flushed;
    logic [31:0] cur_load, cur_iaddr, cur_hitcnt, cur_misscnt;
    assign cur_ihit    = sel_b ? ihit_b    : ihit_a;
    assign cur_iren    = sel_b ? iren_b    : iren_a;
    assign cur_iwait   = sel_b ? iwait_b   : iwait_a;
    assign cur_flushed = sel_b ? flushed_b : flushed_a;
    assign cur_load    = sel_b ? load_b    : load_a;
    assign cur_iaddr   = sel_b ? iaddr_b   : iaddr_a;
    assign cur_hitcnt  = sel_b ? hitcnt_b  : hitcnt_a;
    assign cur_misscnt = sel_b ? misscnt_b : misscnt_a;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: resident tags per set/way plus a round-robin pointer per set.
    int cur_sets = 8;
    int cur_ways = 2;
    int cur_words = 2;
    bit          mval [8][4];
    logic [31:0] mtag [8][4];
    int          mptr [8];
    int          mhit = 0;
    int          mmiss = 0;

    function automatic int m_set(input logic [31:0] a);
        return int'((a >> (2 + $clog2(cur_words))) % 32'(cur_sets));
    endfunction

    function automatic logic [31:0] m_tag(input logic [31:0] a);
        return a >> (2 + $clog2(cur_words) + $clog2(cur_sets));
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        bit h = 1'b0;
        int s = m_set(a);
        for (int w = 0; w < cur_ways; w++)
            if (mval[s][w] && mtag[s][w] == m_tag(a)) h = 1'b1;
        return h;
    endfunction

    task automatic model_fill(input logic [31:0] a);
        int s;
        int v;
        s = m_set(a);
        v = -1;
        for (int w = 0; w < cur_ways && v < 0; w++)
            if (!mval[s][w]) v = w;
        if (v < 0) begin
            v = mptr[s];
            mptr[s] = (mptr[s] + 1) % cur_ways;
        end
        mval[s][v] = 1'b1;
        mtag[s][v] = m_tag(a);
    endtask

    task automatic model_clear();
        for (int s = 0; s < 8; s++) begin
            mptr[s] = 0;
            for (int w = 0; w < 4; w++) mval[s][w] = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        imemREN = 1'b0;
        flush = 1'b0;
        tick();
        RST = 1'b0;
        model_clear();
        mhit = 0;
        mmiss = 0;
    endtask

    task automatic reset_checks();
        @(negedge CLK);
        check("rst_ihit", cur_ihit, 0);
        check("rst_imemload", cur_load, 0);
        check("rst_iren", cur_iren, 0);
        check("rst_iaddr", cur_iaddr, 0);
        check("rst_flushed", cur_flushed, 0);
        check("rst_hitcnt", cur_hitcnt, 0);
        check("rst_misscnt", cur_misscnt, 0);
        tick();
    endtask

    // Starts just after the miss edge; ends just after the edge that takes the last word.
    task automatic fill_words(input logic [31:0] base, input int words);
        int k;
        int guard;
        k = 0;
        guard = 0;
        while (k < words && guard < 64) begin
            @(negedge CLK);
            check("fill_iren", cur_iren, 1);
            if (cur_iren !== 1'b1) break;
            check("fill_iaddr", cur_iaddr, base + 32'(4 * k));
            check("fill_ihit", cur_ihit, 0);
            if (cur_iwait == 1'b0) k++;
            tick();
            guard++;
        end
        if (k != words) check("fill_words_done", k, words);
    endtask

    task automatic access(input logic [31:0] addr, input bit exp_hit, input logic [31:0] exp_data,
                          input bit wiggle, input logic [31:0] alt);
        logic [31:0] base;
        base = addr & ~(32'(cur_words * 4) - 32'd1);
        imemREN = 1'b1;
        imemaddr = addr;
        @(negedge CLK);
        check("ihit", cur_ihit, exp_hit);
        if (exp_hit) begin
            check("hit_data", cur_load, exp_data);
            check("hit_iren", cur_iren, 0);
            tick();
            mhit++;
        end else begin
            check("miss_imemload", cur_load, 0);
            tick();
            mmiss++;
            if (wiggle) imemaddr = alt;
            fill_words(base, cur_words);
            imemaddr = addr;
            @(negedge CLK);
            check("refill_hit", cur_ihit, 1);
            check("refill_data", cur_load, exp_data);
            tick();
            mhit++;
            model_fill(addr);
        end
        imemREN = 1'b0;
        check("hitcnt", cur_hitcnt, 32'(mhit));
        check("misscnt", cur_misscnt, 32'(mmiss));
        $display("access addr=%h %s wait=%0d hitcnt=%0d misscnt=%0d",
                 addr, exp_hit ? "hit" : "miss", mem_wait, cur_hitcnt, cur_misscnt);
    endtask

    // Starts just after the edge that entered INVAL.
    task automatic inval_run(input logic [31:0] addr);
        for (int c = 0; c < cur_sets; c++) begin
            imemREN = (c < cur_sets - 1);
            imemaddr = addr;
            @(negedge CLK);
            check("inval_iren", cur_iren, 0);
            check("inval_ihit", cur_ihit, 0);
            check("inval_flushed_early", cur_flushed, 0);
            tick();
        end
        imemREN = 1'b0;
        @(negedge CLK);
        check("flushed_pulse", cur_flushed, 1);
        tick();
        @(negedge CLK);
        check("flushed_single", cur_flushed, 0);
        tick();
        model_clear();
        $display("invalidate done after %0d cycles", cur_sets);
    endtask

    typedef struct {
        logic [31:0] addr;
        bit          hit;
        logic [31:0] data;
    } vec_t;

    vec_t vec_a [8];
    vec_t vec_b [10];

    initial begin
        logic [31:0] ra;
        logic [31:0] alt;

        vec_a[0] = '{32'h040, 1'b0, 32'hAAAA0001};
        vec_a[1] = '{32'h044, 1'b1, 32'hAAAA0002};
        vec_a[2] = '{32'h0C0, 1'b0, 32'hAAAA0021};
        vec_a[3] = '{32'h040, 1'b1, 32'hAAAA0001};
        vec_a[4] = '{32'h0C4, 1'b1, 32'hAAAA0022};
        vec_a[5] = '{32'h140, 1'b0, 32'hAAAA0041};
        vec_a[6] = '{32'h0C0, 1'b1, 32'hAAAA0021};
        vec_a[7] = '{32'h044, 1'b0, 32'hAAAA0002};

        vec_b[0] = '{32'h000, 1'b0, memf(32'h000)};
        vec_b[1] = '{32'h040, 1'b0, memf(32'h040)};
        vec_b[2] = '{32'h080, 1'b0, memf(32'h080)};
        vec_b[3] = '{32'h0C0, 1'b0, memf(32'h0C0)};
        vec_b[4] = '{32'h100, 1'b0, memf(32'h100)};
        vec_b[5] = '{32'h048, 1'b1, memf(32'h048)};
        vec_b[6] = '{32'h08C, 1'b1, memf(32'h08C)};
        vec_b[7] = '{32'h0C4, 1'b1, memf(32'h0C4)};
        vec_b[8] = '{32'h10C, 1'b1, memf(32'h10C)};
        vec_b[9] = '{32'h004, 1'b0, memf(32'h004)};

        imemaddr = '0;
        do_reset();
        reset_checks();

        for (int i = 0; i < 8; i++)
            access(vec_a[i].addr, vec_a[i].hit, vec_a[i].data, 1'b0, 32'h0);

        // Invalidate with two resident blocks; flush wins over a resident hit.
        do_reset();
        access(32'h040, 1'b0, memf(32'h040), 1'b0, 32'h0);
        access(32'h0C0, 1'b0, memf(32'h0C0), 1'b0, 32'h0);
        imemREN = 1'b1;
        imemaddr = 32'h040;
        flush = 1'b1;
        @(negedge CLK);
        check("flush_priority_ihit", cur_ihit, 0);
        tick();
        flush = 1'b0;
        inval_run(32'h040);
        check("flush_hitcnt", cur_hitcnt, 32'(mhit));
        access(32'h040, 1'b0, memf(32'h040), 1'b0, 32'h0);
        access(32'h0C0, 1'b0, memf(32'h0C0), 1'b0, 32'h0);

        // Flush raised during a fill is held off until the block completes.
        mem_wait = 2;
        imemREN = 1'b1;
        imemaddr = 32'h200;
        @(negedge CLK);
        check("defer_miss", cur_ihit, 0);
        tick();
        mmiss++;
        flush = 1'b1;
        fill_words(32'h200, 2);
        @(negedge CLK);
        check("defer_idle_ihit", cur_ihit, 0);
        check("defer_idle_iren", cur_iren, 0);
        tick();
        flush = 1'b0;
        inval_run(32'h200);
        check("defer_hitcnt", cur_hitcnt, 32'(mhit));
        check("defer_misscnt", cur_misscnt, 32'(mmiss));

        // Reset lands after the first word of a fill.
        mem_wait = 0;
        imemREN = 1'b1;
        imemaddr = 32'h080;
        @(negedge CLK);
        check("rstfill_miss", cur_ihit, 0);
        tick();
        @(negedge CLK);
        check("rstfill_iaddr0", cur_iaddr, 32'h080);
        tick();
        do_reset();
        reset_checks();
        access(32'h080, 1'b0, memf(32'h080), 1'b0, 32'h0);
        access(32'h084, 1'b1, memf(32'h084), 1'b0, 32'h0);

        // Three busy cycles before each word, request address moved to a resident block meanwhile.
        mem_wait = 3;
        access(32'h300, 1'b0, memf(32'h300), 1'b1, 32'h080);
        access(32'h304, 1'b1, memf(32'h304), 1'b0, 32'h0);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                imemREN = 1'b0;
                imemaddr = 32'($urandom_range(0, 32'h17F)) & ~32'h3;
                @(negedge CLK);
                check("idle_ihit", cur_ihit, 0);
                check("idle_iren", cur_iren, 0);
                tick();
                check("idle_hitcnt", cur_hitcnt, 32'(mhit));
                check("idle_misscnt", cur_misscnt, 32'(mmiss));
                $display("idle addr=%h", imemaddr);
            end
            mem_wait = $urandom_range(0, 2);
            ra  = 32'($urandom_range(0, 32'h17F)) & ~32'h3;
            alt = 32'($urandom_range(0, 32'h17F)) & ~32'h3;
            access(ra, model_hit(ra), memf(ra), 1'($urandom_range(0, 1)), alt);
        end

        // Wide configuration: five tags into set 0, fifth evicts way 0.
        sel_b = 1'b1;
        cur_sets = 4;
        cur_ways = 4;
        cur_words = 4;
        mem_wait = 0;
        do_reset();
        reset_checks();
        for (int i = 0; i < 10; i++)
            access(vec_b[i].addr, vec_b[i].hit, vec_b[i].data, 1'b0, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
